// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Req/ack initiator for a 1M x 8 async SRAM with programmable
//            wait states on the strobe-active phase.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int WAIT = 1,
  parameter int AW   = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic          ready,
  output logic          ack,
  output logic [7:0]    rdata,
  output logic [AW-1:0] sram_a,
  inout  wire  [7:0]    sram_d,
  output logic          sram_cs_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  localparam logic [3:0] c_wait = 4'(WAIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WSETUP = 3'd2,
    S_WR     = 3'd3,
    S_WHOLD  = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_a, w_a_nxt;
  logic [7:0]    r_wd, w_wd_nxt;
  logic [7:0]    r_rdata, w_rdata_nxt;
  logic          r_cs_n, w_cs_n_nxt;
  logic          r_oe_n, w_oe_n_nxt;
  logic          r_we_n, w_we_n_nxt;
  logic          r_den, w_den_nxt;
  logic          r_ack, w_ack_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_a     <= '0;
      r_wd    <= 8'h00;
      r_rdata <= 8'h00;
      r_cs_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_den   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_a     <= w_a_nxt;
      r_wd    <= w_wd_nxt;
      r_rdata <= w_rdata_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_we_n  <= w_we_n_nxt;
      r_den   <= w_den_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_a_nxt     = r_a;
    w_wd_nxt    = r_wd;
    w_rdata_nxt = r_rdata;
    w_cs_n_nxt  = r_cs_n;
    w_oe_n_nxt  = r_oe_n;
    w_we_n_nxt  = r_we_n;
    w_den_nxt   = r_den;
    w_ack_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_a_nxt    = addr;
          w_wd_nxt   = wdata;
          w_cs_n_nxt = 1'b0;
          if (rnw) begin
            w_oe_n_nxt  = 1'b0;
            w_cnt_nxt   = c_wait;
            w_state_nxt = S_RD;
          end else begin
            w_den_nxt   = 1'b1;
            w_state_nxt = S_WSETUP;
          end
        end
      end
      S_RD: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_rdata_nxt = sram_d;
          w_cs_n_nxt  = 1'b1;
          w_oe_n_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      // Address and data have been on the pins for a full cycle by now.
      S_WSETUP: begin
        w_we_n_nxt  = 1'b0;
        w_cnt_nxt   = c_wait;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_we_n_nxt  = 1'b1;
          w_state_nxt = S_WHOLD;
        end
      end
      S_WHOLD: begin
        w_cs_n_nxt  = 1'b1;
        w_den_nxt   = 1'b0;
        w_ack_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign ready     = (r_state == S_IDLE);
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign sram_a    = r_a;
  assign sram_cs_n = r_cs_n;
  assign sram_oe_n = r_oe_n;
  assign sram_we_n = r_we_n;
  assign sram_d    = r_den ? r_wd : 8'bz;

endmodule
`default_nettype wire
